// File: rtl/iq_dispatch_sender.sv
// iq_dispatch_sender: holds renamed ops and offers them to the issue queue, then sends min(offer, nextAccepting).
module iq_dispatch_sender #(
   parameter int CAPACITY    = 8,
   parameter int MAX_IN      = 4,
   parameter int MAX_OUT     = 4,
   parameter int STALL_LIMIT = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] prevSending,
   input  logic [7:0] nextAccepting,
   input  logic       lockSend,
   input  logic       lockAccept,
   input  logic       killAll,
   input  logic [7:0] kill,
   output logic [7:0] full,
   output logic [7:0] living,
   output logic [7:0] wantSend,
   output logic [7:0] sending,
   output logic [7:0] canAccept,
   output logic [7:0] headTag,
   output logic       stalled,
   output logic       overflow
);
   localparam logic [7:0] CAP = 8'(CAPACITY);
   localparam logic [7:0] MI  = 8'(MAX_IN);
   localparam logic [7:0] MO  = 8'(MAX_OUT);
   localparam logic [7:0] SL  = 8'(STALL_LIMIT);

   logic [7:0] full_q, full_d, tag_q, tag_d, stall_q, stall_d;
   logic [7:0] after_send, room, accepted;
   logic       ovf_q, ovf_d;

   always_comb begin
      living     = killAll ? 8'd0 : full_q - (kill > full_q ? full_q : kill);
      wantSend   = lockSend ? 8'd0 : (living < MO ? living : MO);
      sending    = wantSend < nextAccepting ? wantSend : nextAccepting;
      after_send = living - sending;
      room       = CAP - after_send;
      // canAccept never sees prevSending, so upstream may use it combinationally
      canAccept  = lockAccept ? 8'd0 : (room < MI ? room : MI);
      accepted   = killAll ? 8'd0 : (prevSending < canAccept ? prevSending : canAccept);
      full_d     = after_send + accepted;
      tag_d      = tag_q + sending;
      stall_d    = (living != 8'd0 && sending == 8'd0) ? (stall_q == 8'hff ? stall_q : stall_q + 8'd1) : 8'd0;
      ovf_d      = ovf_q | (!killAll && prevSending > canAccept);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         full_q  <= '0;
         tag_q   <= '0;
         stall_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         full_q  <= full_d;
         tag_q   <= tag_d;
         stall_q <= stall_d;
         ovf_q   <= ovf_d;
      end
   end

   assign full     = full_q;
   assign headTag  = tag_q;
   assign stalled  = stall_q >= SL;
   assign overflow = ovf_q;
endmodule

// File: tb/tb_iq_dispatch_sender.sv
// tb_iq_dispatch_sender: directed vector table plus hand sequences for tag wrap, stall, overflow and async reset.
module tb_iq_dispatch_sender;
   logic       clk = 1'b0, reset = 1'b1;
   logic [7:0] prevSending = '0, nextAccepting = '0, kill = '0;
   logic       lockSend = 1'b0, lockAccept = 1'b0, killAll = 1'b0;
   logic [7:0] full, living, wantSend, sending, canAccept, headTag;
   logic       stalled, overflow;
   int errors = 0, checks = 0;

   iq_dispatch_sender dut (
      .clk(clk), .reset(reset), .prevSending(prevSending), .nextAccepting(nextAccepting),
      .lockSend(lockSend), .lockAccept(lockAccept), .killAll(killAll), .kill(kill),
      .full(full), .living(living), .wantSend(wantSend), .sending(sending),
      .canAccept(canAccept), .headTag(headTag), .stalled(stalled), .overflow(overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      int ps, na, ls, la, ka, kl;
      int live, want, send, can, fl, tag;
   } vec_t;

   vec_t v[15];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic drive(input int ps, input int na, input int ls, input int la, input int ka, input int kl);
      @(negedge clk);
      prevSending = 8'(ps); nextAccepting = 8'(na); lockSend = ls[0];
      lockAccept = la[0]; killAll = ka[0]; kill = 8'(kl);
      #1;
   endtask

   initial begin
      int full_m, tag_m, sent, aft, na, iter;
      v[0]  = '{4,0,0,0,0,0, 0,0,0,4,4,0};
      v[1]  = '{4,0,0,0,0,0, 4,4,0,4,8,0};
      v[2]  = '{0,0,0,0,0,0, 8,4,0,0,8,0};
      v[3]  = '{0,3,0,0,0,0, 8,4,3,3,5,3};
      v[4]  = '{3,0,0,0,0,0, 5,4,0,3,8,3};
      v[5]  = '{4,4,0,0,0,0, 8,4,4,4,8,7};
      v[6]  = '{0,4,0,0,0,0, 8,4,4,4,4,11};
      v[7]  = '{0,1,0,0,0,0, 4,4,1,4,3,12};
      v[8]  = '{0,4,0,0,0,5, 0,0,0,4,0,12};
      v[9]  = '{4,0,0,0,0,0, 0,0,0,4,4,12};
      v[10] = '{2,0,0,0,0,0, 4,4,0,4,6,12};
      v[11] = '{2,4,0,0,1,3, 0,0,0,4,0,12};
      v[12] = '{2,0,0,0,0,0, 0,0,0,4,2,12};
      v[13] = '{0,3,1,0,0,0, 2,0,0,4,2,12};
      v[14] = '{0,4,0,0,0,1, 1,1,1,4,0,13};

      #12;
      chk("reset_full", full, 0);
      chk("reset_living", living, 0);
      chk("reset_canAccept", canAccept, 4);
      chk("reset_stalled", stalled, 0);
      @(negedge clk) reset = 1'b0;

      for (int i = 0; i < 15; i++) begin
         drive(v[i].ps, v[i].na, v[i].ls, v[i].la, v[i].ka, v[i].kl);
         chk($sformatf("v%0d_living", i), living, v[i].live);
         chk($sformatf("v%0d_wantSend", i), wantSend, v[i].want);
         chk($sformatf("v%0d_sending", i), sending, v[i].send);
         chk($sformatf("v%0d_canAccept", i), canAccept, v[i].can);
         @(posedge clk); #1;
         chk($sformatf("v%0d_full", i), full, v[i].fl);
         chk($sformatf("v%0d_headTag", i), headTag, v[i].tag);
         chk($sformatf("v%0d_overflow", i), overflow, 0);
      end

      full_m = 0; tag_m = 13; iter = 0;
      while (tag_m != 254 && iter < 200) begin
         na = (254 - tag_m) < 4 ? 254 - tag_m : 4;
         drive(4, na, 0, 0, 0, 0);
         @(posedge clk);
         sent = full_m < 4 ? full_m : 4;
         sent = sent < na ? sent : na;
         aft = full_m - sent;
         full_m = aft + ((8 - aft) < 4 ? 8 - aft : 4);
         tag_m += sent;
         iter++;
      end
      #1;
      chk("wrap_pre_tag", headTag, 254);
      chk("wrap_pre_full", full, full_m);
      drive(0, 4, 0, 0, 0, 0);
      chk("wrap_sending", sending, 4);
      @(posedge clk); #1;
      chk("wrap_tag", headTag, 2);

      drive(0, 0, 0, 0, 1, 0);
      @(posedge clk);
      drive(2, 0, 0, 0, 0, 0);
      @(posedge clk); #1;
      chk("stall_full", full, 2);
      for (int c = 1; c <= 16; c++) begin
         drive(0, 0, 0, 0, 0, 0);
         @(posedge clk); #1;
         if (c == 15) chk("stall_c15", stalled, 0);
         if (c == 16) chk("stall_c16", stalled, 1);
      end
      drive(0, 1, 0, 0, 0, 0);
      chk("stall_hold", stalled, 1);
      chk("stall_release_send", sending, 1);
      @(posedge clk); #1;
      chk("stall_clear", stalled, 0);
      chk("stall_full_after", full, 1);

      drive(1, 0, 0, 1, 0, 0);
      chk("ovf_canAccept", canAccept, 0);
      @(posedge clk); #1;
      chk("ovf_set", overflow, 1);
      chk("ovf_full", full, 1);
      drive(0, 0, 0, 0, 0, 0);
      @(posedge clk); #1;
      chk("ovf_sticky", overflow, 1);

      @(negedge clk); #2;
      reset = 1'b1;
      #1;
      chk("areset_full", full, 0);
      chk("areset_tag", headTag, 0);
      chk("areset_ovf", overflow, 0);
      chk("areset_canAccept", canAccept, 4);
      @(negedge clk) reset = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/iq_dispatch_sender.md
# iq_dispatch_sender

Sending end of the issue-queue handshake. It sits between the dispatch pipeline and an issue queue and holds up to CAPACITY renamed ops. Each cycle it computes how many it offers, then sends the minimum of that offer and the queue's `nextAccepting` count. It also reports to upstream how many ops it can take, tracks the sequence tag of the oldest held op, and flags prolonged stalls and protocol overflow.

## Interface

Parameters:
- CAPACITY, 8: maximum ops held; must be ≤ 255.
- MAX_IN, 4: maximum ops accepted per cycle.
- MAX_OUT, 4: maximum ops sent per cycle.
- STALL_LIMIT, 16: consecutive blocked cycles before `stalled` asserts; range 1..255.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- reset, input, 1: asynchronous, active-high reset.
- prevSending, input, 8: ops delivered by upstream this cycle.
- nextAccepting, input, 8: ops the issue queue takes this cycle.
- lockSend, input, 1: forces the send offer to 0.
- lockAccept, input, 1: forces `canAccept` to 0.
- killAll, input, 1: flush; drops all held and incoming ops.
- kill, input, 8: number of youngest held ops to drop this cycle.
- full, output, 8: registered count of held ops.
- living, output, 8: held ops surviving this cycle's kill.
- wantSend, output, 8: ops offered to the issue queue.
- sending, output, 8: ops actually transferred.
- canAccept, output, 8: ops upstream may deliver this cycle.
- headTag, output, 8: sequence tag of the oldest held op.
- stalled, output, 1: blocked for at least STALL_LIMIT cycles.
- overflow, output, 1: sticky protocol-violation flag.

## Operation

Combinational terms, all 8-bit unsigned, evaluated in this order:
- living = killAll ? 0 : full − min(kill, full). Saturating, so it never underflows.
- wantSend = lockSend ? 0 : min(MAX_OUT, living).
- sending = min(wantSend, nextAccepting).
- afterSending = living − sending.
- canAccept = lockAccept ? 0 : min(MAX_IN, CAPACITY − afterSending).
- accepted = killAll ? 0 : min(prevSending, canAccept).

Register updates:
- full ← afterSending + accepted. This is always ≤ CAPACITY.
- headTag ← headTag + sending, mod 256. Wraps 255→0. Kills and killAll do not change it, because killed ops are always the youngest.
- stallCnt (internal, 8-bit) ← stallCnt + 1, saturating at 255, when living > 0, sending == 0 and !killAll. Otherwise it clears to 0.
- stalled = (stallCnt ≥ STALL_LIMIT). Decoded from the register only.
- overflow ← 1 when !killAll and prevSending > canAccept. The excess ops are discarded. Only reset clears it.

No path exists from prevSending to canAccept, so upstream can safely use canAccept combinationally. The sending count depends combinationally on nextAccepting.

## Timing

- Reset (asynchronous, active-high) sets full, headTag, stallCnt and overflow to 0. While reset is held: living = 0, wantSend = 0, sending = 0, stalled = 0. canAccept = min(MAX_IN, CAPACITY) unless lockAccept is high.
- If reset asserts mid-transfer, the transfer is lost; no partial update survives.
- An op accepted in cycle N can be sent no earlier than cycle N+1. Zero-latency bypass is forbidden.
- A send and an accept in the same cycle are both legal. Occupancy is checked after the send (afterSending).
- The transfer count is `sending`. The issue queue must not assume it equals wantSend.
- kill with killAll: killAll dominates.
- kill > full clamps to full.
- lockSend with nextAccepting > 0: sending = 0, and the stall counter advances if living > 0.
- Full condition: when afterSending == CAPACITY, canAccept = 0.
- Empty condition: when full == 0, wantSend = 0 and the stall counter clears.
- The stall counter advances only on registered state plus the current kill result. killAll clears it in the same edge.

## Test plan

- Fill and drain:
  - After reset, apply prevSending = 4 with nextAccepting = 0 for 2 cycles -> full = 4, then full = 8; canAccept = 0 in cycle 3.
  - Then apply nextAccepting = 3 -> sending = 3, full = 5, headTag = 3.
- Simultaneous send and accept: with full = 8, nextAccepting = 4 and prevSending = 4 -> canAccept = 4, sending = 4, full stays 8, headTag advances by 4.
- Kill clamp and killAll:
  - full = 3, kill = 5 -> living = 0, sending = 0, full = 0.
  - full = 6, killAll = 1, prevSending = 2 -> full = 0, overflow stays 0.
- Tag wrap: drive sends until headTag = 254, then send 4 -> headTag = 2.
- Stall: full = 2, nextAccepting = 0 for 16 cycles -> stalled = 1 on the cycle after the 16th.
  - Then nextAccepting = 1 -> stallCnt clears, and stalled = 0 the following cycle.
- Overflow and async reset:
  - With lockAccept = 1, drive prevSending = 1 -> overflow = 1 and full is unchanged.
  - Assert reset between clock edges -> full, headTag and overflow go to 0 immediately.
